shufflenetv2_udiv_eur: RTL
==========================

SHUFFLENETV2_UDIV_EUR -- requirements
Module: shufflenetv2_udiv_eur

Interface
REQ-001 SHALL have parameter ID, default 1, instance identifier with no functional effect.
REQ-002 SHALL have parameter DIVIDEND_W, default 24, dividend width.
REQ-003 SHALL have parameter DIVISOR_W, default 11, divisor and remainder width.
REQ-004 SHALL have parameter QUOT_W, default 13, quotient output width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; port clk input 1 is the rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit, operands valid.
REQ-008 SHALL have port in_ready, output, 1 bit, block can accept operands.
REQ-009 SHALL have port din0, input, DIVIDEND_W bits, unsigned dividend.
REQ-010 SHALL have port din1, input, DIVISOR_W bits, unsigned divisor.
REQ-011 SHALL have port out_valid, output, 1 bit, result valid.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-013 SHALL have port quo, output, QUOT_W bits, quotient (saturated).
REQ-014 SHALL have port rem, output, DIVISOR_W bits, remainder.
REQ-015 SHALL have port ovf, output, 1 bit, true quotient exceeds 2^QUOT_W-1.
REQ-016 SHALL have port dbz, output, 1 bit, divisor was zero.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-018 SHALL, in IDLE with in_valid=1 at a rising edge, latch din0/din1, clear partial remainder, load bit counter with DIVIDEND_W, enter CALC.
REQ-019 SHALL, in CALC, perform one restoring step per cycle, MSB first: shift partial remainder (DIVISOR_W+1 bits) left with next dividend bit, subtract divisor if non-negative, shift quotient bit in.
REQ-020 SHALL enter DONE on the edge completing the DIVIDEND_W-th step; out_valid visible DIVIDEND_W edges after the accepting edge (24 by default).
REQ-021 SHALL hold a full DIVIDEND_W-bit internal quotient; if its value exceeds 2^QUOT_W-1, quo = all ones and ovf=1, else quo = its low QUOT_W bits and ovf=0.
REQ-022 SHALL output rem as the exact remainder regardless of ovf.
REQ-023 SHALL, when accepted divisor is zero, skip CALC, enter DONE on the next edge with quo all ones, rem = dividend low DIVISOR_W bits, dbz=1, ovf=0.
REQ-024 SHALL hold quo/rem/ovf/dbz stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, in DONE with out_ready=1, return to IDLE at that edge; no operand acceptance in the same cycle (in_ready=0 in DONE).
REQ-026 SHALL ignore in_valid outside IDLE and din0/din1 changes after acceptance.
REQ-027 SHALL satisfy din0 = quo*din1 + rem whenever ovf=0 and dbz=0.

Reset
REQ-028 SHALL, on reset assertion at any time (including mid-CALC), asynchronously force IDLE, in_ready=1 after release, out_valid=0, quo=0, rem=0, ovf=0, dbz=0, counter=0.
REQ-029 SHALL discard any in-flight operation on reset; no result is produced for it.

Structure
REQ-030 SHALL place default widths and the FSM state enumeration in shared package shufflenetv2_udiv_pkg.
REQ-031 SHALL implement one restoring step as combinational sub-module shufflenetv2_udiv_eur_step, instantiated once.

Verification
REQ-032 din0=1000000, din1=1000 -> after 24 edges quo=1000, rem=0, ovf=0, dbz=0.
REQ-033 Round trip: din0=7001412 (6844*1023), din1=1023 -> quo=6844, rem=0; random 10k pairs checked against REQ-027.
REQ-034 din0=24'hFFFFFF, din1=11'h7FF -> quo=13'h1FFF, rem=3, ovf=1.
REQ-035 din0=24'h000ABC, din1=0 -> out_valid after 1 edge, quo=13'h1FFF, rem=11'h2BC, dbz=1.
REQ-036 out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready high -> IDLE next edge.
REQ-037 Reset asserted at step 10 of CALC -> all outputs 0 immediately, in_ready=1 after release, next operation correct.

Source files
------------

// File: rtl/shufflenetv2_udiv_pkg.sv
// Shared defaults and FSM state encoding for the restoring unsigned divider.
package shufflenetv2_udiv_pkg;

    localparam int UDIV_DIVIDEND_W = 24;
    localparam int UDIV_DIVISOR_W  = 11;
    localparam int UDIV_QUOT_W     = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } udiv_state_t;

endpackage

// File: rtl/shufflenetv2_udiv_eur_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module shufflenetv2_udiv_eur_step
    import shufflenetv2_udiv_pkg::*;
#(
    parameter int DIVISOR_W = UDIV_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   pr_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   pr_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+2:0] diff;

    // One extra guard bit on the subtraction makes its MSB a clean borrow flag.
    always_comb begin
        shifted = {pr_in, bit_in};
        diff    = {1'b0, shifted} - {3'b000, divisor};
        q_bit   = ~diff[DIVISOR_W+2];
        pr_out  = q_bit ? (DIVISOR_W+1)'(diff) : (DIVISOR_W+1)'(shifted);
    end

endmodule

// File: rtl/shufflenetv2_udiv_eur.sv
// Sequential restoring unsigned divider, one quotient bit per cycle, saturating quotient output.
module shufflenetv2_udiv_eur
    import shufflenetv2_udiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int DIVIDEND_W = UDIV_DIVIDEND_W,
    parameter int DIVISOR_W  = UDIV_DIVISOR_W,
    parameter int QUOT_W     = UDIV_QUOT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quo,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CW        = $clog2(DIVIDEND_W + 1);
    localparam int unused_id = ID;

    udiv_state_t state, state_nxt;

    logic [CW-1:0]         cnt;
    logic [DIVISOR_W-1:0]  dvsr;
    logic [DIVIDEND_W-1:0] work;
    logic [DIVISOR_W:0]    pr;
    logic [DIVISOR_W:0]    pr_nxt;
    logic                  q_bit;
    logic [DIVIDEND_W-1:0] work_nxt;
    logic                  ovf_c;

    shufflenetv2_udiv_eur_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .pr_in  (pr),
        .bit_in (work[DIVIDEND_W-1]),
        .divisor(dvsr),
        .pr_out (pr_nxt),
        .q_bit  (q_bit)
    );

    // Dividend bits shift out of the top of work while quotient bits shift in at the bottom.
    always_comb begin
        work_nxt = {work[DIVIDEND_W-2:0], q_bit};
        ovf_c    = |(work_nxt >> QUOT_W);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (din1 == '0) ? DONE : CALC;
            end
            CALC: begin
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dvsr  <= '0;
            work  <= '0;
            pr    <= '0;
            quo   <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvsr <= din1;
                        work <= din0;
                        pr   <= '0;
                        if (din1 == '0) begin
                            cnt <= '0;
                            quo <= '1;
                            rem <= DIVISOR_W'(din0);
                            ovf <= 1'b0;
                            dbz <= 1'b1;
                        end else begin
                            cnt <= CW'(DIVIDEND_W);
                        end
                    end
                end
                CALC: begin
                    pr   <= pr_nxt;
                    work <= work_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quo <= ovf_c ? '1 : QUOT_W'(work_nxt);
                        rem <= DIVISOR_W'(pr_nxt);
                        ovf <= ovf_c;
                        dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
